// File: rtl/cu_status.sv
// Compute-unit status stage: ASTAT/STKY registers, ureg access and the ASTAT push/pop stack.
// Optional macro CU_STATUS_RDBYP_EN exposes next-state values on the read/sequencer outputs.
module cu_status #(
  parameter int RF_DATASIZE = 16,
  parameter int STK_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mul_ps_mv,
  input  logic                   mul_ps_mn,
  input  logic                   ps_mul_flgen,
  input  logic                   alu_ps_az,
  input  logic                   alu_ps_av,
  input  logic                   alu_ps_an,
  input  logic                   alu_ps_ac,
  input  logic                   ps_alu_flgen,
  input  logic [RF_DATASIZE-1:0] xb_dt,
  input  logic                   ps_sts_wen,
  input  logic                   ps_sts_sel,
  input  logic                   ps_sts_push,
  input  logic                   ps_sts_pop,
  output logic [RF_DATASIZE-1:0] sts_xb_dt,
  output logic [RF_DATASIZE-1:0] sts_astat,
  output logic [RF_DATASIZE-1:0] sts_stky,
  output logic                   sts_stk_full,
  output logic                   sts_stk_empty
);

  localparam int PW = $clog2(STK_DEPTH + 1);
  localparam int AW = $clog2(STK_DEPTH);
  localparam logic [PW-1:0] PTR_MAX  = PW'(STK_DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};

  logic [5:0]    astat_r;
  logic [5:0]    astat_flg_s;
  logic [5:0]    astat_nxt_s;
  logic          avs_r, mvs_r, sso_r, ssu_r;
  logic          avs_nxt_s, mvs_nxt_s, sso_nxt_s, ssu_nxt_s;
  logic [PW-1:0] ptr_r;
  logic [PW-1:0] ptr_nxt_s;
  logic [5:0]    stack_r [STK_DEPTH];
  logic [AW-1:0] wr_idx_s;
  logic [AW-1:0] rd_idx_s;
  logic          full_s, empty_s;
  logic          push_s, pop_s, push_ok_s, pop_ok_s;
  logic          astat_wen_s, stky_wen_s;
  logic          sse_out_s;
  logic [5:0]    astat_out_s;
  logic [RF_DATASIZE-1:0] astat_word_s;
  logic [RF_DATASIZE-1:0] stky_word_s;
  logic          unused_s;

  assign unused_s = ^xb_dt[RF_DATASIZE-1:6];

  // Stack control decode; simultaneous push and pop cancel each other.
  always_comb begin
    full_s      = (ptr_r == PTR_MAX);
    empty_s     = (ptr_r == PTR_ZERO);
    push_s      = ps_sts_push & ~ps_sts_pop;
    pop_s       = ps_sts_pop & ~ps_sts_push;
    push_ok_s   = push_s & ~full_s;
    pop_ok_s    = pop_s & ~empty_s;
    astat_wen_s = ps_sts_wen & ~ps_sts_sel;
    stky_wen_s  = ps_sts_wen & ps_sts_sel;
    wr_idx_s    = AW'(ptr_r);
    rd_idx_s    = AW'(ptr_r - PTR_ONE);
  end

  // ASTAT next state: flags, then ureg write, then pop (highest priority).
  always_comb begin
    astat_flg_s = astat_r;
    if (ps_mul_flgen) begin
      astat_flg_s[5:4] = {mul_ps_mn, mul_ps_mv};
    end else begin
      astat_flg_s[5:4] = astat_r[5:4];
    end
    if (ps_alu_flgen) begin
      astat_flg_s[3:0] = {alu_ps_ac, alu_ps_an, alu_ps_av, alu_ps_az};
    end else begin
      astat_flg_s[3:0] = astat_r[3:0];
    end
    if (pop_ok_s) begin
      astat_nxt_s = stack_r[rd_idx_s];
    end else if (astat_wen_s) begin
      astat_nxt_s = xb_dt[5:0];
    end else begin
      astat_nxt_s = astat_flg_s;
    end
  end

  // STKY next state: a write replaces the sticky bits but same-cycle events are OR-ed in.
  always_comb begin
    if (stky_wen_s) begin
      avs_nxt_s = xb_dt[0];
      mvs_nxt_s = xb_dt[1];
      sso_nxt_s = xb_dt[3];
      ssu_nxt_s = xb_dt[4];
    end else begin
      avs_nxt_s = avs_r;
      mvs_nxt_s = mvs_r;
      sso_nxt_s = sso_r;
      ssu_nxt_s = ssu_r;
    end
    avs_nxt_s = avs_nxt_s | (ps_alu_flgen & alu_ps_av);
    mvs_nxt_s = mvs_nxt_s | (ps_mul_flgen & mul_ps_mv);
    sso_nxt_s = sso_nxt_s | (push_s & full_s);
    ssu_nxt_s = ssu_nxt_s | (pop_s & empty_s);
  end

  // Stack pointer next state.
  always_comb begin
    case ({push_ok_s, pop_ok_s})
      2'b10:   ptr_nxt_s = ptr_r + PTR_ONE;
      2'b01:   ptr_nxt_s = ptr_r - PTR_ONE;
      default: ptr_nxt_s = ptr_r;
    endcase
  end

  // Status state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      astat_r <= 6'h00;
      avs_r   <= 1'b0;
      mvs_r   <= 1'b0;
      sso_r   <= 1'b0;
      ssu_r   <= 1'b0;
      ptr_r   <= PTR_ZERO;
    end else begin
      astat_r <= astat_nxt_s;
      avs_r   <= avs_nxt_s;
      mvs_r   <= mvs_nxt_s;
      sso_r   <= sso_nxt_s;
      ssu_r   <= ssu_nxt_s;
      ptr_r   <= ptr_nxt_s;
    end
  end

  // Stack storage holds the pre-update ASTAT; deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      stack_r[wr_idx_s] <= astat_r;
    end
  end

  // Output view: registered state, or next state when read bypass is built in.
  always_comb begin
`ifdef CU_STATUS_RDBYP_EN
    astat_out_s = astat_nxt_s;
    sse_out_s   = (ptr_nxt_s == PTR_ZERO);
    stky_word_s = {{(RF_DATASIZE-5){1'b0}}, ssu_nxt_s, sso_nxt_s, sse_out_s, mvs_nxt_s, avs_nxt_s};
`else
    astat_out_s = astat_r;
    sse_out_s   = empty_s;
    stky_word_s = {{(RF_DATASIZE-5){1'b0}}, ssu_r, sso_r, sse_out_s, mvs_r, avs_r};
`endif
    astat_word_s = {{(RF_DATASIZE-6){1'b0}}, astat_out_s};
  end

  // Ureg read mux and sequencer outputs.
  always_comb begin
    if (ps_sts_sel) begin
      sts_xb_dt = stky_word_s;
    end else begin
      sts_xb_dt = astat_word_s;
    end
    sts_astat     = astat_word_s;
    sts_stky      = stky_word_s;
    sts_stk_full  = full_s;
    sts_stk_empty = empty_s;
  end

endmodule

// File: tb/tb_cu_status.sv
// Self-checking bench for cu_status: directed test-plan checks plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_cu_status;
  localparam int W = 16;
  localparam int D = 4;

  logic clk = 1'b0;
  logic reset;
  logic mul_ps_mv, mul_ps_mn, ps_mul_flgen;
  logic alu_ps_az, alu_ps_av, alu_ps_an, alu_ps_ac, ps_alu_flgen;
  logic [W-1:0] xb_dt;
  logic ps_sts_wen, ps_sts_sel, ps_sts_push, ps_sts_pop;
  logic [W-1:0] sts_xb_dt, sts_astat, sts_stky;
  logic sts_stk_full, sts_stk_empty;

  cu_status #(.RF_DATASIZE(W), .STK_DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .mul_ps_mv(mul_ps_mv), .mul_ps_mn(mul_ps_mn), .ps_mul_flgen(ps_mul_flgen),
    .alu_ps_az(alu_ps_az), .alu_ps_av(alu_ps_av), .alu_ps_an(alu_ps_an),
    .alu_ps_ac(alu_ps_ac), .ps_alu_flgen(ps_alu_flgen),
    .xb_dt(xb_dt), .ps_sts_wen(ps_sts_wen), .ps_sts_sel(ps_sts_sel),
    .ps_sts_push(ps_sts_push), .ps_sts_pop(ps_sts_pop),
    .sts_xb_dt(sts_xb_dt), .sts_astat(sts_astat), .sts_stky(sts_stky),
    .sts_stk_full(sts_stk_full), .sts_stk_empty(sts_stk_empty)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  // Model state: ASTAT, sticky bits without SSE, and the stack as a queue.
  int m_astat = 0;
  int m_stky  = 0;
  int m_stack[$];
  int u_a, u_s, u_z;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%04h, expected 0x%04h", name, $time, act, exp);
    end
  endtask

  function automatic void model_next(output int na, output int ns, output int nsz);
    bit push, pop;
    int ev;
    push = ps_sts_push && !ps_sts_pop;
    pop  = ps_sts_pop && !ps_sts_push;
    na = m_astat;
    if (ps_mul_flgen) na = (na & 'h0F) + 32 * int'(mul_ps_mn) + 16 * int'(mul_ps_mv);
    if (ps_alu_flgen) na = (na & 'h30) + 8 * int'(alu_ps_ac) + 4 * int'(alu_ps_an)
                           + 2 * int'(alu_ps_av) + int'(alu_ps_az);
    if (ps_sts_wen && !ps_sts_sel) na = int'(xb_dt) & 'h3F;
    nsz = m_stack.size();
    ev = 0;
    if (ps_alu_flgen && alu_ps_av) ev = ev | 1;
    if (ps_mul_flgen && mul_ps_mv) ev = ev | 2;
    if (push) begin
      if (nsz == D) ev = ev | 8;
      else nsz = nsz + 1;
    end
    if (pop) begin
      if (nsz == 0) ev = ev | 16;
      else begin
        na  = m_stack[nsz-1];
        nsz = nsz - 1;
      end
    end
    ns = (((ps_sts_wen && ps_sts_sel) ? int'(xb_dt) : m_stky) & 'h1B) | ev;
  endfunction

  // Model advance on each clock, asynchronous reset
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_astat = 0;
      m_stky  = 0;
      m_stack.delete();
    end else begin
      model_next(u_a, u_s, u_z);
      if (ps_sts_push && !ps_sts_pop && m_stack.size() < D) m_stack.push_back(m_astat);
      else if (ps_sts_pop && !ps_sts_push && m_stack.size() > 0) void'(m_stack.pop_back());
      m_astat = u_a;
      m_stky  = u_s;
    end
  end

  // Per-cycle compare against the model, away from the active edge
  initial forever begin
    int ea, es, esz, sz;
    @(negedge clk);
    if (check_en && reset === 1'b1) begin
      sz = m_stack.size();
`ifdef CU_STATUS_RDBYP_EN
      model_next(ea, es, esz);
`else
      ea = m_astat; es = m_stky; esz = sz;
`endif
      if (esz == 0) es = es | 4;
      chk("cyc_astat", int'(sts_astat), ea);
      chk("cyc_stky", int'(sts_stky), es);
      chk("cyc_xb_dt", int'(sts_xb_dt), ps_sts_sel ? es : ea);
      chk("cyc_full", int'(sts_stk_full), int'(sz == D));
      chk("cyc_empty", int'(sts_stk_empty), int'(sz == 0));
    end
  end

  task automatic idle();
    {mul_ps_mv, mul_ps_mn, ps_mul_flgen} = 3'b000;
    {alu_ps_az, alu_ps_av, alu_ps_an, alu_ps_ac, ps_alu_flgen} = 5'b00000;
    xb_dt = 16'h0000;
    {ps_sts_wen, ps_sts_sel, ps_sts_push, ps_sts_pop} = 4'b0000;
  endtask

  // Let the driven inputs take effect, then idle so outputs are stable in either build.
  task automatic step();
    @(posedge clk);
    #2;
    idle();
    #1;
  endtask

  task automatic ureg_wr(input bit sel, input logic [15:0] d);
    ps_sts_wen = 1'b1; ps_sts_sel = sel; xb_dt = d;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    check_en = 1'b1;
    #1;
    chk("rst_astat", int'(sts_astat), 'h0000);
    chk("rst_stky", int'(sts_stky), 'h0004);
    chk("rst_xb", int'(sts_xb_dt), 'h0000);
    chk("rst_empty", int'(sts_stk_empty), 1);
    chk("rst_full", int'(sts_stk_full), 0);

    // Multiplier flags and MVS
    ps_mul_flgen = 1'b1; mul_ps_mv = 1'b1; mul_ps_mn = 1'b1;
    step();
    chk("mul_astat", int'(sts_astat), 'h0030);
    chk("mul_stky", int'(sts_stky), 'h0006);
    ps_mul_flgen = 1'b1; mul_ps_mv = 1'b0; mul_ps_mn = 1'b1;
    step();
    chk("mul2_astat", int'(sts_astat), 'h0020);
    chk("mul2_stky", int'(sts_stky), 'h0006);

    // ASTAT write overrides ALU flags
    ureg_wr(1'b0, 16'hFFFF); ps_alu_flgen = 1'b1;
    step();
    chk("wr_astat", int'(sts_astat), 'h003F);

    // STKY write merged with a same-cycle MVS event
    ureg_wr(1'b1, 16'h0000); ps_mul_flgen = 1'b1; mul_ps_mv = 1'b1;
    step();
    chk("stkywr_empty", int'(sts_stky), 'h0006);
    ps_sts_push = 1'b1;
    step();
    chk("push1_empty", int'(sts_stk_empty), 0);
    ureg_wr(1'b1, 16'h0000); ps_mul_flgen = 1'b1; mul_ps_mv = 1'b1;
    step();
    chk("stkywr_nonempty", int'(sts_stky), 'h0002);
    ps_sts_pop = 1'b1;
    step();
    chk("pop1_astat", int'(sts_astat), 'h001F);
    chk("pop1_empty", int'(sts_stk_empty), 1);

    // Fill, overflow and drain the stack
    ureg_wr(1'b1, 16'h0000);
    step();
    chk("stky_clr", int'(sts_stky), 'h0004);
    for (int i = 1; i <= 4; i++) begin
      ureg_wr(1'b0, 16'(i));
      step();
      ps_sts_push = 1'b1;
      step();
      chk("fill_full", int'(sts_stk_full), int'(i == 4));
    end
    ps_sts_push = 1'b1;
    step();
    chk("ovf_stky", int'(sts_stky), 'h0008);
    chk("ovf_full", int'(sts_stk_full), 1);
    for (int i = 4; i >= 1; i--) begin
      ps_sts_pop = 1'b1;
      step();
      chk("drain_astat", int'(sts_astat), i);
    end
    chk("drain_empty", int'(sts_stk_empty), 1);
    chk("drain_stky", int'(sts_stky), 'h000C);

    // Underflow and push+pop cancellation
    ps_sts_pop = 1'b1;
    step();
    chk("unf_astat", int'(sts_astat), 'h0001);
    chk("unf_stky", int'(sts_stky), 'h001C);
    ps_sts_push = 1'b1; ps_sts_pop = 1'b1;
    step();
    chk("pp_empty", int'(sts_stk_empty), 1);
    chk("pp_stky", int'(sts_stky), 'h001C);
    ps_sts_push = 1'b1;
    step();
    ps_sts_push = 1'b1; ps_sts_pop = 1'b1;
    step();
    chk("pp1_empty", int'(sts_stk_empty), 0);
    chk("pp1_full", int'(sts_stk_full), 0);
    chk("pp1_stky", int'(sts_stky), 'h0018);
    ps_sts_pop = 1'b1;
    step();

    // Asynchronous reset after two pushes
    ps_sts_push = 1'b1;
    step();
    ps_sts_push = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("arst_astat", int'(sts_astat), 'h0000);
    chk("arst_stky", int'(sts_stky), 'h0004);
    chk("arst_empty", int'(sts_stk_empty), 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;

`ifdef CU_STATUS_RDBYP_EN
    ps_mul_flgen = 1'b1; mul_ps_mv = 1'b1; mul_ps_mn = 1'b1;
    #1;
    chk("byp_astat", int'(sts_astat), 'h0030);
    step();
`endif

    // Randomized traffic, checked every cycle by the compare process
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #2;
      reset        = ($urandom_range(299) == 0) ? 1'b0 : 1'b1;
      ps_mul_flgen = 1'($urandom_range(1));
      mul_ps_mv    = 1'($urandom_range(1));
      mul_ps_mn    = 1'($urandom_range(1));
      ps_alu_flgen = 1'($urandom_range(1));
      alu_ps_az    = 1'($urandom_range(1));
      alu_ps_av    = 1'($urandom_range(1));
      alu_ps_an    = 1'($urandom_range(1));
      alu_ps_ac    = 1'($urandom_range(1));
      xb_dt        = 16'($urandom);
      ps_sts_wen   = ($urandom_range(7) == 0);
      ps_sts_sel   = 1'($urandom_range(1));
      ps_sts_push  = ($urandom_range(3) == 0);
      ps_sts_pop   = ($urandom_range(3) == 0);
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cu_status.md
Name: cu_status

Overview:
- Compute-unit status stage, directly downstream of the multiplier and ALU.
- Latches the execute-cycle flags (multiplier MV/MN, ALU AZ/AV/AN/AC) into the ASTAT register and accumulates the sticky bits in STKY.
- Both registers are readable and writable as universal registers over the xb data bus.
- Provides a push/pop status stack (PUSH STS / POP STS).
- Drives ASTAT/STKY to the sequencer for condition evaluation.

Parameters:
- RF_DATASIZE, 16, width of the xb data bus and of the ASTAT/STKY registers.
- STK_DEPTH, 4, number of ASTAT entries in the status stack (2..16).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- mul_ps_mv  input  1  multiplier overflow flag, valid in the execute cycle.
- mul_ps_mn  input  1  multiplier sign flag, valid in the execute cycle.
- ps_mul_flgen  input  1  execute-cycle qualifier: multiplier flags update ASTAT.
- alu_ps_az, alu_ps_av, alu_ps_an, alu_ps_ac  input  1 each  ALU flags, valid in the execute cycle.
- ps_alu_flgen  input  1  execute-cycle qualifier: ALU flags update ASTAT.
- xb_dt  input  RF_DATASIZE  write data for ureg writes.
- ps_sts_wen  input  1  ureg write strobe.
- ps_sts_sel  input  1  register select: 0 = ASTAT, 1 = STKY; used for both read and write.
- ps_sts_push  input  1  push ASTAT onto the status stack.
- ps_sts_pop  input  1  pop the status stack into ASTAT.
- sts_xb_dt  output  RF_DATASIZE  ureg read data.
- sts_astat  output  RF_DATASIZE  current ASTAT, to the sequencer.
- sts_stky  output  RF_DATASIZE  current STKY, to the sequencer.
- sts_stk_full  output  1  status stack holds STK_DEPTH entries.
- sts_stk_empty  output  1  status stack holds 0 entries.

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-low.
- Reset values:
  - ASTAT = 0.
  - STKY = 0x0004 (SSE = 1).
  - Stack pointer = 0.
  - sts_stk_empty = 1, sts_stk_full = 0, sts_xb_dt = 0.
  - Stack storage is not reset.
- ASTAT bit map: [0] AZ, [1] AV, [2] AN, [3] AC, [4] MV, [5] MN. Bits [RF_DATASIZE-1:6] always read 0 and ignore writes.
- STKY bit map: [0] AVS, [1] MVS, [2] SSE, [3] SSO, [4] SSU. All other bits read 0.
  - SSE is read-only and equals sts_stk_empty.
  - SSO and SSU are sticky.
- Flag update:
  - If ps_mul_flgen is high, MV/MN are loaded from mul_ps_mv/mul_ps_mn at posedge.
  - If ps_alu_flgen is high, AZ/AV/AN/AC are loaded from the ALU flags at posedge.
  - Bits whose qualifier is low hold their value.
  - Latency is 1: flags presented in cycle N are visible on sts_astat in cycle N+1.
- Sticky update:
  - MVS is set by ps_mul_flgen & mul_ps_mv.
  - AVS is set by ps_alu_flgen & alu_ps_av.
  - Sticky bits clear only through a STKY write.
- ASTAT ureg write: the written value (masked to defined bits) replaces ASTAT and overrides same-cycle flag updates.
- STKY ureg write: new STKY = (xb_dt masked) | same-cycle sticky events, so events are never lost. Bit 2 (SSE) ignores write data.
- Read: sts_xb_dt is combinational, equal to ASTAT or STKY per ps_sts_sel. A read in the same cycle as an update returns the pre-update value.
- Push, not full: stack[ptr] <= ASTAT (pre-update register value); ptr increments.
- Push, full: no change to stack or ptr; SSO is set.
- Pop, not empty: ASTAT <= stack[ptr-1]; ptr decrements. Pop overrides same-cycle flag updates and ASTAT writes. Sticky events still apply.
- Pop, empty: ASTAT follows the normal update rules; SSU is set.
- Push and pop in the same cycle: both ignored, no error bits set.
- sts_stk_full = (ptr == STK_DEPTH); sts_stk_empty = (ptr == 0). Both are registered-state derived.
- Reset asserted mid-operation: returns immediately to reset values; pending strobes are discarded.

Optional Feature:
- Macro: CU_STATUS_RDBYP_EN.
- Defined: sts_xb_dt, sts_astat and sts_stky return the next-state value (including same-cycle flag updates, writes and pops), giving 0-cycle flag-to-condition latency.
- Undefined: all three outputs show registered values only (1-cycle latency).

Test Plan:
- Reset, then ps_mul_flgen = 1, mv = 1, mn = 1 for one cycle:
  - next cycle sts_astat = 0x0030, sts_stky = 0x0006.
  - a further cycle with mv = 0 gives sts_astat = 0x0020; MVS stays 1.
- ASTAT write 0xFFFF with ps_alu_flgen = 1 (all ALU flags 0) in the same cycle: sts_astat = 0x003F.
- STKY write 0x0000 in the same cycle as mul mv = 1: sts_stky = 0x0002 with the stack non-empty, 0x0006 with it empty.
- Push 5 times with STK_DEPTH = 4 and ASTAT = 0x0001..0x0004 before each push:
  - sts_stk_full = 1 after the 4th push.
  - 5th push sets SSO (STKY bit 3).
  - 4 pops return ASTAT 0x0004, 0x0003, 0x0002, 0x0001.
  - sts_stk_empty = 1 and SSE = 1 afterwards.
- Pop on an empty stack: ASTAT unchanged, SSU set. Simultaneous push and pop: ptr and STKY unchanged.
- Assert reset mid-sequence after 2 pushes: ptr = 0, ASTAT = 0, STKY = 0x0004 asynchronously. With CU_STATUS_RDBYP_EN defined, rerun scenario 1 and check sts_astat = 0x0030 in the same cycle.
